// File: rtl/esp8266_pkg.sv
// rtl/esp8266_pkg.sv - shared states, ASCII constants and reply patterns for the ESP8266 command sequencer
package esp8266_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_FETCH,
      ST_SEND,
      ST_WAIT_OK,
      ST_GAP,
      ST_FINISH,
      ST_FAIL
   } state_t;

   localparam logic [7:0] ASCII_CR  = 8'h0D;
   localparam logic [7:0] ASCII_LF  = 8'h0A;
   localparam logic [7:0] ASCII_O   = 8'h4F;
   localparam logic [7:0] ASCII_K   = 8'h4B;
   localparam logic [7:0] ASCII_END = 8'h00;

   localparam logic [31:0] OK_PATTERN    = {ASCII_O, ASCII_K, ASCII_CR, ASCII_LF};
   localparam logic [55:0] ERROR_PATTERN = {8'h45, 8'h52, 8'h52, 8'h4F, 8'h52, ASCII_CR, ASCII_LF};

endpackage

// File: rtl/esp8266_cmd_rom.sv
// rtl/esp8266_cmd_rom.sv - synchronous byte ROM holding the AT command table
module esp8266_cmd_rom
   import esp8266_pkg::*;
#(
   parameter int unsigned ROM_AW = 6
) (
   input  logic              Clk,
   input  logic [ROM_AW-1:0] addr,
   output logic [7:0]        data
);

   localparam int unsigned TABLE_LEN = 35;

   // Each command ends in CR LF; a 0x00 where a command would start ends the table.
   localparam logic [7:0] TABLE [0:TABLE_LEN-1] = '{
      "A", "T", "+", "C", "I", "P", "M", "U", "X", "=", "1", ASCII_CR, ASCII_LF,
      "A", "T", "+", "C", "I", "P", "S", "E", "R", "V", "E", "R", "=", "1", ",",
      "8", "0", "8", "0", ASCII_CR, ASCII_LF,
      ASCII_END
   };

   always_ff @(posedge Clk) begin
      if (addr < ROM_AW'(TABLE_LEN)) begin
         data <= TABLE[addr];
      end else begin
         data <= ASCII_END;
      end
   end

endmodule

// File: rtl/esp8266_cmd_seq.sv
// rtl/esp8266_cmd_seq.sv - AT command sequencer with OK handshake and retries; ESP_ERROR_DETECT_EN adds ERROR reply detection
module esp8266_cmd_seq
   import esp8266_pkg::*;
#(
   parameter int unsigned ROM_AW      = 6,
   parameter int unsigned TIMEOUT_CYC = 5000000,
   parameter int unsigned GAP_CYC     = 2500,
   parameter int unsigned MAX_RETRY   = 3
) (
   input  logic       Clk,
   input  logic       Rst_n,
   input  logic       Start,
   output logic [7:0] Tx_data,
   output logic       Tx_valid,
   input  logic       Tx_ready,
   input  logic [7:0] Rx_data,
   input  logic       Rx_valid,
   output logic       Busy,
   output logic       Done,
   output logic       Error,
   output logic [3:0] Cmd_idx
);

`ifdef ESP_ERROR_DETECT_EN
   localparam int unsigned MW = 56;
`else
   localparam int unsigned MW = 32;
`endif

   state_t              state_q, state_d;
   logic [ROM_AW-1:0]   addr_q, addr_d;
   logic [ROM_AW-1:0]   base_q, base_d;
   logic [7:0]          retry_q, retry_d;
   logic [31:0]         timer_q, timer_d;
   logic [MW-1:0]       match_q, match_d;
   logic [MW-1:0]       match_sh;
   logic [7:0]          tx_data_q, tx_data_d;
   logic                tx_valid_q, tx_valid_d;
   logic                done_q, done_d;
   logic                error_q, error_d;
   logic [3:0]          idx_q, idx_d;
   logic                ok_hit, err_hit, timeout;
   logic [7:0]          rom_data;

   // The ROM is addressed with the next address so its data is ready in FETCH.
   esp8266_cmd_rom #(.ROM_AW(ROM_AW)) u_rom (
      .Clk  (Clk),
      .addr (addr_d),
      .data (rom_data)
   );

   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         state_q    <= ST_IDLE;
         addr_q     <= '0;
         base_q     <= '0;
         retry_q    <= '0;
         timer_q    <= '0;
         match_q    <= '0;
         tx_data_q  <= '0;
         tx_valid_q <= 1'b0;
         done_q     <= 1'b0;
         error_q    <= 1'b0;
         idx_q      <= '0;
      end else begin
         state_q    <= state_d;
         addr_q     <= addr_d;
         base_q     <= base_d;
         retry_q    <= retry_d;
         timer_q    <= timer_d;
         match_q    <= match_d;
         tx_data_q  <= tx_data_d;
         tx_valid_q <= tx_valid_d;
         done_q     <= done_d;
         error_q    <= error_d;
         idx_q      <= idx_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      addr_d     = addr_q;
      base_d     = base_q;
      retry_d    = retry_q;
      timer_d    = timer_q;
      match_d    = match_q;
      tx_data_d  = tx_data_q;
      tx_valid_d = tx_valid_q;
      done_d     = done_q;
      error_d    = error_q;
      idx_d      = idx_q;
      match_sh   = Rx_valid ? {match_q[MW-9:0], Rx_data} : match_q;
      ok_hit     = Rx_valid && (match_sh[31:0] == OK_PATTERN);
`ifdef ESP_ERROR_DETECT_EN
      err_hit    = Rx_valid && (match_sh == ERROR_PATTERN);
`else
      err_hit    = 1'b0;
`endif
      timeout    = (timer_q == TIMEOUT_CYC - 1);

      case (state_q)
         ST_IDLE: begin
            if (Start) begin
               done_d  = 1'b0;
               error_d = 1'b0;
               addr_d  = '0;
               base_d  = '0;
               retry_d = '0;
               idx_d   = '0;
               state_d = ST_FETCH;
            end
         end
         ST_FETCH: begin
            if (rom_data == ASCII_END && addr_q == base_q) begin
               state_d = ST_FINISH;
            end else begin
               tx_data_d  = rom_data;
               tx_valid_d = 1'b1;
               state_d    = ST_SEND;
            end
         end
         ST_SEND: begin
            if (Tx_ready) begin
               tx_valid_d = 1'b0;
               addr_d     = addr_q + ROM_AW'(1);
               if (tx_data_q == ASCII_LF) begin
                  match_d = '0;
                  timer_d = '0;
                  state_d = ST_WAIT_OK;
               end else begin
                  state_d = ST_FETCH;
               end
            end
         end
         ST_WAIT_OK: begin
            match_d = match_sh;
            timer_d = timer_q + 32'd1;
            // An OK arriving on the timeout cycle still counts as success.
            if (ok_hit) begin
               base_d  = addr_q;
               retry_d = '0;
               idx_d   = (idx_q == 4'd15) ? idx_q : idx_q + 4'd1;
               timer_d = '0;
               state_d = ST_GAP;
            end else if (err_hit || timeout) begin
               if (retry_q == 8'(MAX_RETRY)) begin
                  state_d = ST_FAIL;
               end else begin
                  retry_d = retry_q + 8'd1;
                  addr_d  = base_q;
                  state_d = ST_FETCH;
               end
            end
         end
         ST_GAP: begin
            timer_d = timer_q + 32'd1;
            if (timer_q == GAP_CYC - 1) begin
               state_d = ST_FETCH;
            end
         end
         ST_FINISH: begin
            done_d  = 1'b1;
            state_d = ST_IDLE;
         end
         ST_FAIL: begin
            error_d = 1'b1;
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   assign Tx_data  = tx_data_q;
   assign Tx_valid = tx_valid_q;
   assign Busy     = (state_q != ST_IDLE);
   assign Done     = done_q;
   assign Error    = error_q;
   assign Cmd_idx  = idx_q;

endmodule

// File: doc/esp8266_cmd_seq.md
Name: esp8266_cmd_seq

Overview:
Sequences the ESP8266 AT-command bring-up (for example AT+CIPMUX=1 and AT+CIPSERVER=1,8080) into the UART transmitter, one byte at a time, over a valid/ready handshake. After each command it waits for the module's "OK\r\n" reply on the UART receive stream. It retries on timeout and reports done or error to the top-level control. It replaces free-running byte streaming with a flow-controlled, acknowledged sequence.

Parameters:
ROM_AW, 6, address width of command byte table (64 entries)
TIMEOUT_CYC, 5000000, cycles to wait for "OK" after a command terminator (100 ms at 50 MHz)
GAP_CYC, 2500, idle cycles inserted after OK before next command
MAX_RETRY, 3, resend attempts per command before error

Ports:
Clk  input  1  system clock
Rst_n  input  1  asynchronous active-low reset
Start  input  1  single-cycle pulse; begins sequence from table entry 0
Tx_data  output  8  byte to UART TX
Tx_valid  output  1  Tx_data valid
Tx_ready  input  1  UART TX accepts byte when high with Tx_valid
Rx_data  input  8  byte from UART RX
Rx_valid  input  1  single-cycle strobe, Rx_data valid
Busy  output  1  sequence in progress
Done  output  1  sticky; all commands acknowledged
Error  output  1  sticky; retries exhausted
Cmd_idx  output  4  index of current command, 0-based

Behaviour:
- Clock and reset: one clock, Clk. Reset is asynchronous and active-low, on Rst_n.
- Reset values:
  - Tx_data=0, Tx_valid=0, Busy=0, Done=0, Error=0, Cmd_idx=0
  - FSM=IDLE
  - all counters 0
- Command table:
  - Byte ROM, synchronous read, 1-cycle latency.
  - Each command ends with 0x0D,0x0A.
  - Byte 0x00 at a command start marks end of table.
- FSM states: IDLE, FETCH, SEND, WAIT_OK, GAP, FINISH, FAIL.
  - IDLE: Start -> clear Done/Error, addr=0, cmd_base=0, retry=0, Cmd_idx=0 -> FETCH.
  - FETCH: issue ROM read, 1 cycle. Next cycle: if byte==0x00 at cmd_base -> FINISH; else load Tx_data and assert Tx_valid -> SEND.
  - SEND: Tx_valid and Tx_data held stable until Tx_ready. On Tx_valid&&Tx_ready: addr++, and Tx_valid drops in the same cycle it is accepted (registered low next cycle). If the accepted byte==0x0A -> clear match register, timer=0 -> WAIT_OK; else -> FETCH. Throughput is one byte per 2 cycles at best.
  - WAIT_OK: 32-bit shift register of the last 4 Rx bytes. A match of 0x4F,0x4B,0x0D,0x0A ("OK\r\n") -> cmd_base=addr, retry=0, Cmd_idx++ -> GAP.
  - WAIT_OK timeout: timer reaching TIMEOUT_CYC-1 -> if retry==MAX_RETRY -> FAIL; else retry++, addr=cmd_base -> FETCH (whole command resent).
  - GAP: count GAP_CYC cycles -> FETCH.
  - FINISH: Done=1, Busy=0 -> IDLE.
  - FAIL: Error=1, Busy=0 -> IDLE.
- Busy=1 in every state except IDLE.
- Start while Busy is ignored.
- Rx bytes outside WAIT_OK are discarded; the match register is cleared on entry to WAIT_OK, so a stale "OK" never matches.
- An OK match and timeout in the same cycle: the OK wins.
- Address wraps at 2^ROM_AW; the table must contain a 0x00 terminator.
- Cmd_idx saturates at 15.
- Rst_n low mid-transfer: Tx_valid drops immediately (async); the sequence is lost and requires a new Start.

Optional Feature:
- Macro ESP_ERROR_DETECT_EN.
- Defined: the matcher also recognises "ERROR\r\n" (last 7 bytes) in WAIT_OK and takes the retry/fail path immediately, without waiting for timeout. The shift register widens to 56 bits.
- Undefined: only "OK\r\n" is matched; ERROR replies are ignored and resolved by timeout.

Decomposition:
- Shared package esp8266_pkg:
  - FSM state enum
  - ASCII constants: CR=0x0D, LF=0x0A, 'O', 'K', END=0x00
  - OK/ERROR match patterns
- One sub-module, esp8266_cmd_rom: synchronous byte ROM holding the command table (AT+CIPMUX=1\r\n, AT+CIPSERVER=1,8080\r\n, 0x00). The table is separated so commands can change without touching the FSM.

Test Plan:
- Reset, then Start, with Tx_ready always 1 and the bench replying "OK\r\n" after each LF -> Tx emits exactly the 13 bytes of AT+CIPMUX=1\r\n, then the 21 bytes of AT+CIPSERVER=1,8080\r\n. A gap of at least GAP_CYC separates the two commands; Cmd_idx goes 0->1->2; Done=1, Busy=0.
- Tx_ready toggling pseudo-randomly -> Tx_data stable while Tx_valid&&!Tx_ready; no byte is dropped or duplicated; the byte stream matches the table.
- No reply to command 0 (TIMEOUT_CYC reduced to 1000) -> the command is resent 3 times, then Error=1, Done=0, Busy=0, Cmd_idx=0.
- Bench sends "OK\r\n" during SEND of command 1, then nothing -> the early OK is not accepted; timeout retry occurs.
- With ESP_ERROR_DETECT_EN, reply "ERROR\r\n" -> retry starts within 2 cycles of the final LF, without waiting for timeout.
- Rst_n asserted mid-SEND, then Start again -> all outputs return to reset values immediately; the sequence restarts from byte 0x41 ('A').
